// File: rtl/pulse_input_conditioner_pkg.sv
// pulse_cond_pkg: width helpers and legal parameter ranges for the pulse input conditioner.
package pulse_cond_pkg;

    localparam int NCH_MIN      = 1;
    localparam int NCH_MAX      = 8;
    localparam int FILT_LEN_MIN = 1;
    localparam int FILT_LEN_MAX = 15;
    localparam int RTC_DIV_MIN  = 1;
    localparam int RTC_DIV_MAX  = 256;

    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int filt_w(input int filt_len);
        return clog2_min1(filt_len);
    endfunction

    function automatic int pre_w(input int rtc_div);
        return clog2_min1(rtc_div);
    endfunction

    function automatic bit params_ok(input int nch, input int filt_len, input int rtc_div);
        return nch >= NCH_MIN && nch <= NCH_MAX &&
               filt_len >= FILT_LEN_MIN && filt_len <= FILT_LEN_MAX &&
               rtc_div >= RTC_DIV_MIN && rtc_div <= RTC_DIV_MAX;
    endfunction

endpackage

// File: rtl/pulse_input_conditioner_input_filter.sv
// input_filter: 2-FF synchroniser plus persistence filter; strobes qualified rises and reports rejected glitches.
module input_filter
    import pulse_cond_pkg::*;
#(
    parameter int FILT_LEN = 3
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_ena,
    input  logic i_raw,
    output logic o_level,
    output logic o_pulse,
    output logic o_rise,
    output logic o_glitch
);

    localparam int                FILT_W = filt_w(FILT_LEN);
    localparam logic [FILT_W-1:0] LAST   = FILT_W'(FILT_LEN - 1);

    logic              r_s1;
    logic              r_s2;
    logic              r_level;
    logic              r_pulse;
    logic [FILT_W-1:0] r_cnt;
    logic              w_diff;
    logic              w_flip;

    assign w_diff   = r_s2 != r_level;
    assign w_flip   = i_ena && w_diff && r_cnt == LAST;
    assign o_rise   = w_flip && r_s2;
    // a disagreeing run that ends before qualifying is a rejected glitch
    assign o_glitch = i_ena && !w_diff && r_cnt != '0;
    assign o_level  = r_level;
    assign o_pulse  = r_pulse;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_s1    <= 1'b0;
            r_s2    <= 1'b0;
            r_level <= 1'b0;
            r_pulse <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_s1    <= i_raw;
            r_s2    <= r_s1;
            r_pulse <= o_rise;
            if (i_ena) begin
                if (w_flip) begin
                    r_level <= r_s2;
                    r_cnt   <= '0;
                end else begin
                    r_cnt <= w_diff ? r_cnt + 1'b1 : '0;
                end
            end
        end
    end

endmodule

// File: rtl/pulse_input_conditioner.sv
// pulse_input_conditioner: filters NCH channel inputs and the RTC input into edge strobes,
// prescales RTC rises into rtc_tick and keeps sticky per-input glitch flags.
module pulse_input_conditioner
    import pulse_cond_pkg::*;
#(
    parameter int NCH      = 4,
    parameter int FILT_LEN = 3,
    parameter int RTC_DIV  = 1
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    input  logic           i_ena,
    input  logic [NCH-1:0] i_ch_in,
    input  logic           i_rtc_in,
    input  logic           i_clr_glitch,
    output logic [NCH-1:0] o_ch_level,
    output logic [NCH-1:0] o_ch_pulse,
    output logic           o_rtc_tick,
    output logic [NCH:0]   o_glitch_flag
);

    localparam int               PRE_W    = pre_w(RTC_DIV);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(RTC_DIV - 1);

    if (!params_ok(NCH, FILT_LEN, RTC_DIV)) begin : g_bad_params
        $error("pulse_input_conditioner: parameter out of range");
    end

    logic [NCH:0]     w_raw;
    logic [NCH:0]     w_level;
    logic [NCH:0]     w_pulse;
    logic [NCH:0]     w_rise;
    logic [NCH:0]     w_glitch;
    logic             w_unused;
    logic [PRE_W-1:0] r_pcnt;
    logic             r_tick;
    logic [NCH:0]     r_flag;

    // bit NCH of every per-input vector is the RTC path
    assign w_raw = {i_rtc_in, i_ch_in};

    for (genvar i = 0; i <= NCH; i++) begin : g_in
        input_filter #(.FILT_LEN(FILT_LEN)) u_filt (
            .i_clk   (i_clk),
            .i_rst_n (i_rst_n),
            .i_ena   (i_ena),
            .i_raw   (w_raw[i]),
            .o_level (w_level[i]),
            .o_pulse (w_pulse[i]),
            .o_rise  (w_rise[i]),
            .o_glitch(w_glitch[i])
        );
    end

    assign w_unused      = ^{w_level[NCH], w_pulse[NCH], w_rise[NCH-1:0]};
    assign o_ch_level    = w_level[NCH-1:0];
    assign o_ch_pulse    = w_pulse[NCH-1:0];
    assign o_rtc_tick    = r_tick;
    assign o_glitch_flag = r_flag;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pcnt <= '0;
            r_tick <= 1'b0;
            r_flag <= '0;
        end else begin
            r_tick <= w_rise[NCH] && r_pcnt == PRE_LAST;
            if (w_rise[NCH])
                r_pcnt <= (r_pcnt == PRE_LAST) ? '0 : r_pcnt + 1'b1;
            // a glitch seen on the clearing edge survives the clear
            r_flag <= (i_clr_glitch ? '0 : r_flag) | w_glitch;
        end
    end

endmodule

// File: tb/tb_pulse_input_conditioner.sv
// tb_pulse_input_conditioner: directed and random checks of two builds (FILT_LEN=3/RTC_DIV=4 and FILT_LEN=1/RTC_DIV=1)
// against a cycle-level behavioural model of synchroniser, persistence filter and RTC prescaler.
module tb_pulse_input_conditioner;

    localparam int NCH = 4;

    logic           clk    = 1'b0;
    logic           rst_n  = 1'b0;
    logic           ena    = 1'b0;
    logic           rtc_in = 1'b0;
    logic           clr    = 1'b0;
    logic [NCH-1:0] ch_in  = '0;
    logic [NCH-1:0] lvl_a, pls_a, lvl_b, pls_b;
    logic           tick_a, tick_b;
    logic [NCH:0]   gf_a, gf_b;

    int n_assert = 0;
    int n_fail   = 0;

    int fl[2] = '{3, 1};
    int dv[2] = '{4, 1};

    logic [NCH:0] m_s1[2], m_s2[2], m_lvl[2], m_pls[2], m_gf[2];
    logic         m_tick[2];
    int           m_run[2][NCH+1];
    int           m_rises[2];

    int pc_a[NCH], pc_b[NCH];
    int tk_a, tk_b;
    int tick_pos[$];

    always #5 clk = ~clk;

    pulse_input_conditioner #(.NCH(NCH), .FILT_LEN(3), .RTC_DIV(4)) dut_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_ena(ena), .i_ch_in(ch_in), .i_rtc_in(rtc_in),
        .i_clr_glitch(clr), .o_ch_level(lvl_a), .o_ch_pulse(pls_a), .o_rtc_tick(tick_a),
        .o_glitch_flag(gf_a)
    );

    pulse_input_conditioner #(.NCH(NCH), .FILT_LEN(1), .RTC_DIV(1)) dut_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_ena(ena), .i_ch_in(ch_in), .i_rtc_in(rtc_in),
        .i_clr_glitch(clr), .o_ch_level(lvl_b), .o_ch_pulse(pls_b), .o_rtc_tick(tick_b),
        .o_glitch_flag(gf_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < 2; c++) begin
            m_s1[c] = '0; m_s2[c] = '0; m_lvl[c] = '0; m_pls[c] = '0; m_gf[c] = '0;
            m_tick[c] = 1'b0; m_rises[c] = 0;
            for (int k = 0; k <= NCH; k++) m_run[c][k] = 0;
        end
    endtask

    // a level changes after fl consecutive enabled samples disagree with it;
    // a disagreeing run cut short by an agreeing sample is a glitch
    task automatic model_edge();
        logic [NCH:0] raw, rise, gl;
        if (!rst_n) begin
            model_reset();
            return;
        end
        raw = {rtc_in, ch_in};
        for (int c = 0; c < 2; c++) begin
            rise = '0;
            gl   = '0;
            if (ena) begin
                for (int k = 0; k <= NCH; k++) begin
                    if (m_s2[c][k] != m_lvl[c][k]) begin
                        m_run[c][k]++;
                        if (m_run[c][k] == fl[c]) begin
                            m_lvl[c][k] = m_s2[c][k];
                            m_run[c][k] = 0;
                            rise[k]     = m_lvl[c][k];
                        end
                    end else begin
                        gl[k]       = m_run[c][k] > 0;
                        m_run[c][k] = 0;
                    end
                end
            end
            m_pls[c]  = rise;
            m_tick[c] = 1'b0;
            if (rise[NCH]) begin
                m_rises[c]++;
                m_tick[c] = (m_rises[c] % dv[c]) == 0;
            end
            m_gf[c] = (clr ? '0 : m_gf[c]) | gl;
            m_s2[c] = m_s1[c];
            m_s1[c] = raw;
        end
    endtask

    task automatic chk_all();
        chk("level_a", lvl_a, m_lvl[0][NCH-1:0]);
        chk("pulse_a", pls_a, m_pls[0][NCH-1:0]);
        chk("tick_a", tick_a, m_tick[0]);
        chk("gflag_a", gf_a, m_gf[0]);
        chk("level_b", lvl_b, m_lvl[1][NCH-1:0]);
        chk("pulse_b", pls_b, m_pls[1][NCH-1:0]);
        chk("tick_b", tick_b, m_tick[1]);
        chk("gflag_b", gf_b, m_gf[1]);
    endtask

    task automatic clear_counts();
        for (int k = 0; k < NCH; k++) begin
            pc_a[k] = 0;
            pc_b[k] = 0;
        end
        tk_a = 0;
        tk_b = 0;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        chk_all();
        for (int k = 0; k < NCH; k++) begin
            pc_a[k] += int'(pls_a[k]);
            pc_b[k] += int'(pls_b[k]);
        end
        tk_a += int'(tick_a);
        tk_b += int'(tick_b);
    endtask

    initial begin
        model_reset();
        clear_counts();
        #2;
        chk_all();
        repeat (2) step();

        // partially filtered inputs, then an asynchronous reset
        rst_n = 1'b1;
        ena   = 1'b1;
        ch_in = 4'hF;
        repeat (3) step();
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        chk_all();
        chk("rst_async_level", lvl_b, 4'h0);
        repeat (2) step();
        rst_n = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            step();
            chk("rst_rel_pulse_a", pls_a, i == 5 ? 4'hF : 4'h0);
            chk("rst_rel_pulse_b", pls_b, i == 3 ? 4'hF : 4'h0);
        end

        // single-clock high on all channels
        ch_in = '0;
        repeat (6) step();
        ch_in = 4'hF;
        for (int i = 1; i <= 6; i++) begin
            step();
            ch_in = '0;
            chk("fl1_pulse_b", pls_b, i == 3 ? 4'hF : 4'h0);
            chk("fl1_pulse_a", pls_a, 4'h0);
        end
        chk("fl1_glitch_a", gf_a, 5'h0F);
        repeat (4) step();

        // glitch, clear, and glitch coincident with clear
        clr = 1'b1; step(); clr = 1'b0;
        chk("clr_all", gf_a, 5'h00);
        clear_counts();
        ch_in[0] = 1'b1; repeat (2) step(); ch_in[0] = 1'b0; repeat (6) step();
        chk("glitch_nopulse", pc_a[0], 0);
        chk("glitch_flag", gf_a[0], 1'b1);
        clr = 1'b1; step(); clr = 1'b0;
        chk("glitch_clr", gf_a[0], 1'b0);
        ch_in[0] = 1'b1; repeat (2) step(); ch_in[0] = 1'b0; repeat (2) step();
        clr = 1'b1; step(); clr = 1'b0;
        chk("glitch_vs_clr", gf_a[0], 1'b1);
        repeat (4) step();

        // qualified train on channel 2
        clear_counts();
        repeat (10) begin
            ch_in[2] = 1'b1; repeat (4) step();
            ch_in[2] = 1'b0; repeat (4) step();
        end
        repeat (6) step();
        chk("train_cnt_a", pc_a[2], 10);
        chk("train_cnt_b", pc_b[2], 10);
        chk("train_gflag", gf_a[2], 1'b0);

        // RTC prescaler
        clr = 1'b1; step(); clr = 1'b0;
        clear_counts();
        for (int j = 0; j < 8; j++) begin
            for (int s = 0; s < 8; s++) begin
                rtc_in = s < 4;
                step();
                if (tick_a) tick_pos.push_back(j * 8 + s);
            end
        end
        repeat (6) step();
        chk("rtc_ticks_a", tk_a, 2);
        chk("rtc_ticks_b", tk_b, 8);
        chk("rtc_tick_first", tick_pos.size() > 0 ? tick_pos[0] : -1, 3 * 8 + 4);
        chk("rtc_tick_second", tick_pos.size() > 1 ? tick_pos[1] : -1, 7 * 8 + 4);
        chk("rtc_gflag", gf_a[NCH], 1'b0);

        // enable gating
        clear_counts();
        ena      = 1'b0;
        ch_in[1] = 1'b1;
        repeat (6) step();
        chk("ena_off_pulses", pc_a[1] + pc_b[1], 0);
        ena = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            step();
            chk("ena_on_a", pls_a[1], i == 3);
            chk("ena_on_b", pls_b[1], i == 1);
        end
        ch_in = '0;
        repeat (6) step();

        // random traffic
        for (int n = 0; n < 3000; n++) begin
            rst_n = 1'b1;
            for (int k = 0; k < NCH; k++)
                if ($urandom_range(3) == 0) ch_in[k] = ~ch_in[k];
            if ($urandom_range(3) == 0) rtc_in = ~rtc_in;
            ena = $urandom_range(15) != 0;
            clr = $urandom_range(31) == 0;
            if ($urandom_range(999) == 0) begin
                rst_n = 1'b0;
                #1;
                model_reset();
                chk_all();
            end
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
